// File: rtl/reorder_buffer_param_if.sv
// Bus bundle between the reorder buffer and its neighbours: dispatch,
// the writeback buses, the register file / memory controller and the
// fetch redirect. The master side is the environment and the slave side
// is the reorder buffer.
interface reorder_buffer_param_if #(
    parameter int TAG_W    = 4,
    parameter int WB_PORTS = 3
) ();
    logic                      rdy_in;
    // dispatch
    logic                      issue_valid;
    logic                      issue_ready;
    logic [TAG_W-1:0]          issue_tag;
    logic [31:0]               issue_pc;
    logic [4:0]                issue_rd;
    logic [1:0]                issue_kind;
    logic                      issue_pred_taken;
    // writeback buses
    logic [WB_PORTS-1:0]       wb_valid;
    logic [WB_PORTS*TAG_W-1:0] wb_tag;
    logic [WB_PORTS*32-1:0]    wb_data;
    logic [WB_PORTS*32-1:0]    wb_pc;
    // retirement
    logic                      commit_valid;
    logic [TAG_W-1:0]          commit_tag;
    logic [4:0]                commit_rd;
    logic [31:0]               commit_data;
    logic [31:0]               commit_pc;
    // memory handshake for stores
    logic                      store_req;
    logic                      store_done_in;
    // redirect
    logic                      flush_out;
    logic [31:0]               flush_pc;
    logic [TAG_W:0]            count_out;

    modport master (
        output rdy_in, issue_valid, issue_pc, issue_rd, issue_kind, issue_pred_taken,
        output wb_valid, wb_tag, wb_data, wb_pc, store_done_in,
        input  issue_ready, issue_tag, commit_valid, commit_tag, commit_rd,
        input  commit_data, commit_pc, store_req, flush_out, flush_pc, count_out
    );

    modport slave (
        input  rdy_in, issue_valid, issue_pc, issue_rd, issue_kind, issue_pred_taken,
        input  wb_valid, wb_tag, wb_data, wb_pc, store_done_in,
        output issue_ready, issue_tag, commit_valid, commit_tag, commit_rd,
        output commit_data, commit_pc, store_req, flush_out, flush_pc, count_out
    );
endinterface

// File: rtl/reorder_buffer_param.sv
// Parametrised in-order retirement buffer. Tags are allocated at the tail
// on issue, results arrive on WB_PORTS writeback buses in any order, and
// the head retires one instruction per cycle in program order. Stores wait
// for the memory controller; a mispredicted branch retires and then
// triggers a one-cycle flush that empties the buffer.
module reorder_buffer_param #(
    parameter int DEPTH    = 16,
    parameter int TAG_W    = 4,
    parameter int WB_PORTS = 3
) (
    input logic                   clk_in,
    input logic                   rst_n_in,
    reorder_buffer_param_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STORE_WAIT = 2'd1,
        ST_FLUSH      = 2'd2
    } state_t;

    localparam logic [1:0]     KIND_BRANCH = 2'd1;
    localparam logic [1:0]     KIND_STORE  = 2'd2;
    localparam logic [TAG_W:0] DEPTH_CNT   = (TAG_W + 1)'(DEPTH);

    state_t           state_reg, state_next;
    logic [TAG_W-1:0] head_reg, tail_reg;
    logic [TAG_W:0]   count_reg, count_next;
    logic [DEPTH-1:0] valid_reg, ready_reg;

    // Per-entry payload; no reset needed because valid_reg guards it.
    logic [1:0]  kind_mem   [DEPTH];
    logic        pred_mem   [DEPTH];
    logic [4:0]  rd_mem     [DEPTH];
    logic [31:0] pc_mem     [DEPTH];
    logic [31:0] data_mem   [DEPTH];
    logic [31:0] target_mem [DEPTH];

    logic             commit_valid_reg;
    logic [TAG_W-1:0] commit_tag_reg;
    logic [4:0]       commit_rd_reg;
    logic [31:0]      commit_data_reg;
    logic [31:0]      commit_pc_reg;
    logic             store_req_reg;
    logic             flush_reg;
    logic [31:0]      flush_pc_reg;

    logic issue_ready_w, issue_fire;
    logic retire, flush_start, flush_clear, store_start, store_finish;

    logic [TAG_W-1:0]    wb_tag_arr  [WB_PORTS];
    logic [31:0]         wb_data_arr [WB_PORTS];
    logic [31:0]         wb_pc_arr   [WB_PORTS];
    logic [WB_PORTS-1:0] wb_accept;

    // Unpack each writeback bus; a result is taken only for a live entry
    // and never while the buffer is being flushed or frozen.
    genvar gi;
    generate
        for (gi = 0; gi < WB_PORTS; gi++) begin : g_port
            assign wb_tag_arr[gi]  = bus.wb_tag[gi*TAG_W +: TAG_W];
            assign wb_data_arr[gi] = bus.wb_data[gi*32 +: 32];
            assign wb_pc_arr[gi]   = bus.wb_pc[gi*32 +: 32];
            assign wb_accept[gi]   = bus.rdy_in && (state_reg != ST_FLUSH) &&
                                     bus.wb_valid[gi] && valid_reg[wb_tag_arr[gi]];
        end
    endgenerate

    logic        head_valid, head_ready, head_pred;
    logic [1:0]  head_kind;
    logic [31:0] head_data;

    assign head_valid = valid_reg[head_reg];
    assign head_ready = ready_reg[head_reg];
    assign head_kind  = kind_mem[head_reg];
    assign head_pred  = pred_mem[head_reg];
    assign head_data  = data_mem[head_reg];

    // The full check deliberately ignores a retire in the same cycle.
    assign issue_ready_w = (state_reg != ST_FLUSH) && (count_reg < DEPTH_CNT);
    assign issue_fire    = bus.rdy_in && bus.issue_valid && issue_ready_w;
    assign count_next    = count_reg + (TAG_W + 1)'(issue_fire) - (TAG_W + 1)'(retire);

    // Next-state and retire decisions, evaluated on the registered head.
    always_comb begin
        state_next   = state_reg;
        retire       = 1'b0;
        flush_start  = 1'b0;
        flush_clear  = 1'b0;
        store_start  = 1'b0;
        store_finish = 1'b0;
        if (bus.rdy_in) begin
            case (state_reg)
                ST_RUN: begin
                    if (head_valid && head_ready) begin
                        if (head_kind == KIND_STORE) begin
                            store_start = 1'b1;
                            state_next  = ST_STORE_WAIT;
                        end else if (head_kind == KIND_BRANCH && head_data[0] != head_pred) begin
                            retire      = 1'b1;
                            flush_start = 1'b1;
                            state_next  = ST_FLUSH;
                        end else begin
                            retire = 1'b1;
                        end
                    end
                end
                ST_STORE_WAIT: begin
                    if (bus.store_done_in) begin
                        retire       = 1'b1;
                        store_finish = 1'b1;
                        state_next   = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    flush_clear = 1'b1;
                    state_next  = ST_RUN;
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    // State register; a frozen cycle simply re-selects the current state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Pointers, occupancy and per-entry valid/ready flags.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
            ready_reg <= '0;
        end else if (bus.rdy_in) begin
            if (flush_clear) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
                valid_reg <= '0;
                ready_reg <= '0;
            end else begin
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_accept[p]) begin
                        ready_reg[wb_tag_arr[p]] <= 1'b1;
                    end
                end
                if (issue_fire) begin
                    valid_reg[tail_reg] <= 1'b1;
                    ready_reg[tail_reg] <= 1'b0;
                    tail_reg            <= tail_reg + 1'b1;
                end
                if (retire) begin
                    valid_reg[head_reg] <= 1'b0;
                    head_reg            <= head_reg + 1'b1;
                end
                count_reg <= count_next;
            end
        end
    end

    // Payload writes; later ports overwrite earlier ones so the highest
    // port index wins a same-tag collision.
    always_ff @(posedge clk_in) begin
        if (bus.rdy_in) begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_accept[p]) begin
                    data_mem[wb_tag_arr[p]]   <= wb_data_arr[p];
                    target_mem[wb_tag_arr[p]] <= wb_pc_arr[p];
                end
            end
            if (issue_fire) begin
                kind_mem[tail_reg] <= bus.issue_kind;
                pred_mem[tail_reg] <= bus.issue_pred_taken;
                rd_mem[tail_reg]   <= bus.issue_rd;
                pc_mem[tail_reg]   <= bus.issue_pc;
            end
        end
    end

    // Registered retire, store-request and redirect outputs; the pulses
    // are cleared on a frozen cycle so they cannot repeat afterwards.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            commit_valid_reg <= 1'b0;
            commit_tag_reg   <= '0;
            commit_rd_reg    <= '0;
            commit_data_reg  <= '0;
            commit_pc_reg    <= '0;
            store_req_reg    <= 1'b0;
            flush_reg        <= 1'b0;
            flush_pc_reg     <= '0;
        end else if (!bus.rdy_in) begin
            commit_valid_reg <= 1'b0;
            flush_reg        <= 1'b0;
        end else begin
            commit_valid_reg <= retire;
            flush_reg        <= flush_start;
            if (retire) begin
                commit_tag_reg  <= head_reg;
                commit_rd_reg   <= store_finish ? 5'd0 : rd_mem[head_reg];
                commit_data_reg <= head_data;
                commit_pc_reg   <= pc_mem[head_reg];
            end
            if (flush_start) begin
                flush_pc_reg <= target_mem[head_reg];
            end
            if (store_start) begin
                store_req_reg <= 1'b1;
            end else if (store_finish) begin
                store_req_reg <= 1'b0;
            end
        end
    end

    assign bus.issue_ready  = issue_ready_w;
    assign bus.issue_tag    = tail_reg;
    assign bus.commit_valid = commit_valid_reg && bus.rdy_in;
    assign bus.commit_tag   = commit_tag_reg;
    assign bus.commit_rd    = commit_rd_reg;
    assign bus.commit_data  = commit_data_reg;
    assign bus.commit_pc    = commit_pc_reg;
    assign bus.store_req    = store_req_reg;
    assign bus.flush_out    = flush_reg && bus.rdy_in;
    assign bus.flush_pc     = flush_pc_reg;
    assign bus.count_out    = count_reg;
endmodule
